sample_frame_buffer: RTL and testbench

SAMPLE_FRAME_BUFFER -- requirements
Module: sample_frame_buffer

---
 rtl/sample_frame_buffer_pkg.sv | 18 +
 rtl/sample_frame_buffer_if.sv | 26 ++
 rtl/sample_edge_detect.sv | 22 ++
 rtl/sample_frame_buffer.sv | 89 ++++++++
 tb/tb_sample_frame_buffer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/sample_frame_buffer_pkg.sv
// Shared types and defaults for the sample frame buffer.
// No logic; FSM state encoding, width constants and a saturating increment.
package sample_frame_buffer_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } sfb_state_t;

    localparam int DATA_W_DEF    = 12;
    localparam int FRAME_LEN_DEF = 64;
    localparam int OVR_W         = 8;

    function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sample_frame_buffer_if.sv
// Frame beat stream: valid/ready handshake with data and end-of-frame marker.
// Master drives the beat and holds it stable while ready is low.
interface sample_frame_buffer_if
    import sample_frame_buffer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/sample_edge_detect.sv
// Rising-edge pulse on an already-synchronous strobe; combinational pulse, one register.
// Previous value resets high so a strobe held high through reset gives no pulse.
module sample_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/sample_frame_buffer.sv
// Captures one frame of samples on sample_clk edges, then streams it out in order.
// Beats appear the cycle after the final write; a stalled beat holds, edges during drain count as overruns.
module sample_frame_buffer
    import sample_frame_buffer_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    input  logic                  sample_clk,
    input  logic [DATA_W-1:0]     sample_in,
    sample_frame_buffer_if.master out_if,
    output logic [OVR_W-1:0]      overrun_cnt
);

    localparam int               PTR_W    = $clog2(FRAME_LEN);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FRAME_LEN - 1);

    sfb_state_t        state_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [OVR_W-1:0]  ovr_q;
    logic [DATA_W-1:0] mem_q [FRAME_LEN];

    logic rise;
    logic xfer;
    logic last_xfer;
    logic wr_en;

    sample_edge_detect u_edge (
        .clk    (CLOCK),
        .rst_n  (RESET_N),
        .sig_i  (sample_clk),
        .rise_o (rise)
    );

    assign xfer      = (state_q == DRAIN) && out_if.out_ready;
    assign last_xfer = xfer && (rd_ptr_q == LAST_IDX);
    // wr_ptr_q is always 0 during DRAIN, so the coincident write lands in slot 0.
    assign wr_en     = rise && ((state_q == FILL) || last_xfer);

    always_ff @(posedge CLOCK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= FILL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovr_q    <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (rise) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        if (wr_ptr_q == LAST_IDX) begin
                            state_q  <= DRAIN;
                            rd_ptr_q <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                    end
                    if (last_xfer) begin
                        state_q <= FILL;
                        if (rise) begin
                            wr_ptr_q <= PTR_W'(1);
                        end
                    end else if (rise) begin
                        ovr_q <= sat_inc(ovr_q);
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign out_if.out_valid = (state_q == DRAIN);
    assign out_if.out_last  = (state_q == DRAIN) && (rd_ptr_q == LAST_IDX);
    assign out_if.out_data  = mem_q[rd_ptr_q];
    assign overrun_cnt      = ovr_q;

endmodule

// File: tb/tb_sample_frame_buffer.sv
// Scoreboard bench for sample_frame_buffer: stimulus pushes expected beats, a negedge monitor checks them.
module tb_sample_frame_buffer;
    import sample_frame_buffer_pkg::*;

    localparam int DW = 12;
    localparam int FL = 64;

    logic          CLOCK      = 1'b0;
    logic          RESET_N    = 1'b0;
    logic          sample_clk = 1'b1;
    logic [DW-1:0] sample_in  = '1;
    logic [7:0]    overrun_cnt;

    sample_frame_buffer_if #(.DATA_W(DW)) bus ();

    sample_frame_buffer #(.DATA_W(DW), .FRAME_LEN(FL)) dut (
        .CLOCK       (CLOCK),
        .RESET_N     (RESET_N),
        .sample_clk  (sample_clk),
        .sample_in   (sample_in),
        .out_if      (bus),
        .overrun_cnt (overrun_cnt)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    idx      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] v);
        beat_t b;
        b.d    = v;
        b.last = (idx == FL - 1);
        exp_q.push_back(b);
        idx = (idx == FL - 1) ? 0 : idx + 1;
    endtask

    // Monitor: every stalled cycle re-compares against the same queue head.
    always @(negedge CLOCK) begin
        if (RESET_N) begin
            if (bus.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=0x%0h required=none at %0t", bus.out_data, $time);
                end else begin
                    chk("beat_data", 32'(bus.out_data), 32'(exp_q[0].d));
                    chk("beat_last", 32'(bus.out_last), 32'(exp_q[0].last));
                    if (bus.out_ready === 1'b1) void'(exp_q.pop_front());
                end
            end else begin
                chk("last_idle", 32'(bus.out_last), 32'd0);
            end
        end
    end

    // Entered and left at posedge+1; sample_clk low 3 cycles then high 3 cycles.
    task automatic do_edge(input logic [DW-1:0] v, input bit push, input bit chk_rise);
        sample_clk = 1'b0;
        repeat (3) @(posedge CLOCK);
        #1;
        sample_in  = v;
        sample_clk = 1'b1;
        if (push) push_exp(v);
        if (chk_rise) begin
            @(negedge CLOCK);
            chk("valid_early", 32'(bus.out_valid), 32'd0);
            @(negedge CLOCK);
            chk("valid_rise", 32'(bus.out_valid), 32'd1);
            repeat (2) @(posedge CLOCK);
            #1;
        end else begin
            repeat (3) @(posedge CLOCK);
            #1;
        end
    endtask

    task automatic fill_frame(input logic [DW-1:0] base);
        for (int i = 0; i < FL; i++) begin
            do_edge(base + DW'(i), 1'b1, i == FL - 1);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge CLOCK);
            n++;
        end
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d_left required=0_left", exp_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus.out_ready = 1'b0;

        // Reset with sample_clk held high
        repeat (3) @(posedge CLOCK);
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_last", 32'(bus.out_last), 32'd0);
        chk("rst_ovr", 32'(overrun_cnt), 32'd0);
        @(negedge CLOCK);
        RESET_N = 1'b1;
        repeat (10) @(posedge CLOCK);
        #1;
        chk("no_capture_high", 32'(bus.out_valid), 32'd0);

        // Full frame 0..63 with ready held high
        bus.out_ready = 1'b1;
        fill_frame(12'h000);
        wait_drain(200);
        chk("ovr_after_fill", 32'(overrun_cnt), 32'd0);

        // Random backpressure during drain
        bus.out_ready = 1'b0;
        fill_frame(12'h800);
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge CLOCK);
            #1;
            n++;
        end
        chk("random_drain_left", 32'(exp_q.size()), 32'd0);
        chk("ovr_after_random", 32'(overrun_cnt), 32'd0);

        // Edge coincident with the final transfer
        bus.out_ready = 1'b0;
        fill_frame(12'h100);
        bus.out_ready = 1'b1;
        repeat (FL - 1) @(posedge CLOCK);
        #1;
        bus.out_ready = 1'b0;
        sample_clk = 1'b0;
        repeat (3) @(posedge CLOCK);
        #1;
        chk("pre_coincide_last", 32'(bus.out_last), 32'd1);
        sample_in     = 12'hABC;
        sample_clk    = 1'b1;
        bus.out_ready = 1'b1;
        push_exp(12'hABC);
        @(negedge CLOCK);
        @(negedge CLOCK);
        chk("coincide_back_to_fill", 32'(bus.out_valid), 32'd0);
        chk("coincide_ovr", 32'(overrun_cnt), 32'd0);
        @(posedge CLOCK);
        #1;
        for (int i = 1; i < FL; i++) begin
            do_edge(12'h200 + DW'(i), 1'b1, i == FL - 1);
        end
        wait_drain(200);
        chk("ovr_after_coincide", 32'(overrun_cnt), 32'd0);

        // Overrun counting and saturation
        bus.out_ready = 1'b0;
        fill_frame(12'h300);
        for (int i = 0; i < 5; i++) do_edge(12'h7FF, 1'b0, 1'b0);
        chk("ovr_5", 32'(overrun_cnt), 32'd5);
        for (int i = 5; i < 300; i++) do_edge(12'h7FF, 1'b0, 1'b0);
        chk("ovr_sat", 32'(overrun_cnt), 32'd255);
        bus.out_ready = 1'b1;
        wait_drain(200);
        chk("ovr_held", 32'(overrun_cnt), 32'd255);

        // Reset in the middle of a drain
        bus.out_ready = 1'b0;
        fill_frame(12'h500);
        bus.out_ready = 1'b1;
        repeat (10) @(posedge CLOCK);
        #1;
        bus.out_ready = 1'b0;
        #2;
        RESET_N = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_last", 32'(bus.out_last), 32'd0);
        chk("midrst_ovr", 32'(overrun_cnt), 32'd0);
        exp_q.delete();
        idx = 0;
        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK);
        RESET_N = 1'b1;
        @(posedge CLOCK);
        #1;
        chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        fill_frame(12'h600);
        wait_drain(200);
        chk("post_rst_ovr", 32'(overrun_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
